rr_sel_arbiter_4ch: RTL

//  Four-channel round-robin arbiter that sits directly upstream of the 4:1 mux.
//  It drives the mux sel[1:0] port and a one-hot grant to the sources.

---
 rtl/rr_sel_arbiter_4ch.sv | 79 +++++++
 1 files changed

// File: rtl/rr_sel_arbiter_4ch.sv
// rr_sel_arbiter_4ch: four-channel round-robin arbiter driving a 4:1 mux select
// and a one-hot grant, with a per-grant hold limit of HOLD_MAX cycles.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   req   : per-channel level request, sampled on clk
//   sel   : registered index of the granted channel (holds while idle)
//   gnt   : registered one-hot grant, zero when idle
//   busy  : registered, high while a grant is active
module rr_sel_arbiter_4ch #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_e;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, base, win;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d, end_grant;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        // A finishing grant moves ptr to the granted channel on the same edge,
        // so the search base is sel_q in GRANT and ptr_q in IDLE.
        base = (state_q == GRANT) ? sel_q : ptr_q;
        win  = base;
        // Descending loop so the lowest offset (highest priority) wins.
        for (int i = 4; i >= 1; i--)
            if (req[base + 2'(i)]) win = base + 2'(i);
        end_grant = (state_q == GRANT) && (!req[sel_q] || cnt_q == CNT_MAX);
        state_d   = state_q;
        ptr_d     = end_grant ? sel_q : ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        if (state_q == IDLE || end_grant) begin
            if (|req) begin
                state_d = GRANT;
                sel_d   = win;
                gnt_d   = 4'b0001 << win;
                busy_d  = 1'b1;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end
    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
endmodule
